// File: rtl/lif_pkg.sv
// Shared constants and FSM state type for the LIF neuron scheduler.
package lif_pkg;

    localparam logic [31:0] ONE                = 32'h0001_0000;
    localparam logic [31:0] VTH_DEFAULT        = 32'h0000_fc93;
    localparam int unsigned LEAK_SHIFT_DEFAULT = 3;
    localparam int unsigned FRAC_W             = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDiff,
        StAcc,
        StCmp,
        StSpike,
        StDone
    } lif_state_e;

endpackage

// File: rtl/lif_update_dp.sv
// Shared leaky-integrate update datapath: d = cur - v, a = v + (d >>> LEAK_SHIFT),
// plus the threshold compare on the registered result.
module lif_update_dp
    import lif_pkg::*;
#(
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       LEAK_SHIFT = LEAK_SHIFT_DEFAULT,
    parameter logic [DATA_W-1:0] VTH        = DATA_W'(VTH_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              diff_en,
    input  logic              acc_en,
    input  logic [DATA_W-1:0] cur_data,
    input  logic [DATA_W-1:0] v_r,
    output logic [DATA_W-1:0] acc,
    output logic              fire
);

    // Difference carries one extra bit so cur - v never wraps.
    logic signed [DATA_W:0] d_q;
    logic signed [DATA_W:0] d_shift;
    logic        [DATA_W:0] sum;
    logic [DATA_W-1:0]      a_q;

    assign d_shift = d_q >>> LEAK_SHIFT;
    assign sum     = {v_r[DATA_W-1], v_r} + d_shift;

    // Stage registers: difference in DIFF, leaky accumulate in ACC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_q <= '0;
            a_q <= '0;
        end else begin
            if (diff_en) begin
                d_q <= {cur_data[DATA_W-1], cur_data} - {v_r[DATA_W-1], v_r};
            end
            if (acc_en) begin
                a_q <= sum[DATA_W-1:0];
            end
        end
    end

    assign acc  = a_q;
    assign fire = $signed(a_q) >= $signed(VTH);

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed LIF scheduler: walks all virtual neurons through one shared
// update datapath per tick, keeps potentials in a register file, emits spikes
// on a valid/ready stream.
module lif_neuron_scheduler
    import lif_pkg::*;
#(
    parameter int unsigned       N_NEURONS  = 8,
    parameter int unsigned       IDX_W      = 3,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       LEAK_SHIFT = LEAK_SHIFT_DEFAULT,
    parameter logic [DATA_W-1:0] VTH        = DATA_W'(VTH_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_valid,
    output logic              tick_ready,
    input  logic              clr,
    output logic [IDX_W-1:0]  cur_idx,
    input  logic [DATA_W-1:0] cur_data,
    output logic              spike_valid,
    input  logic              spike_ready,
    output logic [IDX_W-1:0]  spike_idx,
    output logic [DATA_W-1:0] vmem_out,
    output logic              step_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    lif_state_e        state_q;
    logic [IDX_W-1:0]  n_q;
    logic [DATA_W-1:0] v_r_q;
    logic [DATA_W-1:0] v_mem [N_NEURONS];

    logic              diff_en;
    logic              acc_en;
    logic [DATA_W-1:0] acc;
    logic              fire;
    logic              advance;

    assign tick_ready = (state_q == StIdle);
    assign diff_en    = (state_q == StDiff);
    assign acc_en     = (state_q == StAcc);

    // Move on to the next neuron after a quiet write-back or an accepted spike.
    assign advance = ((state_q == StCmp) && !fire) || ((state_q == StSpike) && spike_ready);

    lif_update_dp #(
        .DATA_W     (DATA_W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .VTH        (VTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .diff_en  (diff_en),
        .acc_en   (acc_en),
        .cur_data (cur_data),
        .v_r      (v_r_q),
        .acc      (acc),
        .fire     (fire)
    );

    // Step sequencer, potential register file and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            n_q         <= '0;
            v_r_q       <= '0;
            cur_idx     <= '0;
            spike_valid <= 1'b0;
            spike_idx   <= '0;
            vmem_out    <= '0;
            step_done   <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= '0;
            end
        end else begin
            step_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clr) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            v_mem[i] <= '0;
                        end
                    end else if (tick_valid) begin
                        n_q     <= '0;
                        cur_idx <= '0;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    // cur_idx already points at n; its current arrives during DIFF.
                    v_r_q   <= v_mem[n_q];
                    state_q <= StDiff;
                end
                StDiff: begin
                    state_q <= StAcc;
                end
                StAcc: begin
                    state_q <= StCmp;
                end
                StCmp: begin
                    if (fire) begin
                        v_mem[n_q]  <= '0;
                        vmem_out    <= '0;
                        spike_idx   <= n_q;
                        spike_valid <= 1'b1;
                        state_q     <= StSpike;
                    end else begin
                        v_mem[n_q] <= acc;
                        vmem_out   <= acc;
                    end
                end
                StSpike: begin
                    if (spike_ready) begin
                        spike_valid <= 1'b0;
                    end
                end
                StDone: begin
                    step_done <= 1'b1;
                    state_q   <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (advance) begin
                if (n_q == LAST_IDX) begin
                    state_q <= StDone;
                end else begin
                    n_q     <= n_q + 1'b1;
                    cur_idx <= n_q + 1'b1;
                    state_q <= StLoad;
                end
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Self-checking bench for lif_neuron_scheduler: a step-level behavioural model
// predicts every write-back, spike and step_done time; directed cases pin it
// to hand-computed values, then randomized currents and backpressure follow.
module tb_lif_neuron_scheduler;

    localparam int          N    = 8;
    localparam logic [31:0] VTH  = 32'h0000_fc93;
    localparam int          LEAK = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_valid;
    logic        tick_ready;
    logic        clr;
    logic [2:0]  cur_idx;
    logic [31:0] cur_data;
    logic        spike_valid;
    logic        spike_ready;
    logic [2:0]  spike_idx;
    logic [31:0] vmem_out;
    logic        step_done;

    int total = 0;
    int bad   = 0;

    logic [31:0] cur_mem [N];
    logic [31:0] model_v [N];
    logic [31:0] wb [N];
    int          steps_done  = 0;
    int          step_spikes = 0;
    int          last_spike  = 0;
    int          last_cycles = 0;
    int          done_pulses = 0;
    bit          ready_mode  = 1'b0;
    bit          ready_force = 1'b1;

    lif_neuron_scheduler dut (
        .clk         (clk),
        .rst         (rst),
        .tick_valid  (tick_valid),
        .tick_ready  (tick_ready),
        .clr         (clr),
        .cur_idx     (cur_idx),
        .cur_data    (cur_data),
        .spike_valid (spike_valid),
        .spike_ready (spike_ready),
        .spike_idx   (spike_idx),
        .vmem_out    (vmem_out),
        .step_done   (step_done)
    );

    always #5 clk = ~clk;

    // Current fabric: data for cur_idx appears one cycle after the index.
    always @(posedge clk) cur_data <= cur_mem[cur_idx];

    always @(negedge clk) if (step_done) done_pulses <= done_pulses + 1;

    // Downstream ready: forced level or random backpressure.
    initial begin
        spike_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode) spike_ready = ($urandom_range(0, 2) != 0);
            else            spike_ready = ready_force;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One LIF step for a single neuron, straight from the update equation.
    function automatic logic [31:0] lif_next(input logic [31:0] v, input logic [31:0] c);
        longint vs, cs, d, a;
        vs = longint'($signed(v));
        cs = longint'($signed(c));
        d  = cs - vs;
        a  = vs + (d >>> LEAK);
        return a[31:0];
    endfunction

    function automatic bit fires(input logic [31:0] a);
        return $signed(a) >= $signed(VTH);
    endfunction

    task automatic zero_model();
        for (int i = 0; i < N; i++) model_v[i] = 32'h0;
    endtask

    task automatic wait_neg(output bit ab);
        @(negedge clk);
        ab = !rst;
    endtask

    // Called on the negedge before the accepting edge; follows one whole step.
    task automatic check_step();
        logic [31:0] a;
        bit          ab;
        int          waits;
        int          guard;
        waits       = 0;
        step_spikes = 0;
        wait_neg(ab); waits++;
        if (ab) return;
        for (int i = 0; i < N; i++) begin
            chk("load_cur_idx", 32'(cur_idx), 32'(i));
            chk("busy_tick_ready", 32'(tick_ready), 32'h0);
            a = lif_next(model_v[i], cur_mem[i]);
            for (int k = 0; k < 4; k++) begin
                wait_neg(ab); waits++;
                if (ab) return;
                chk("busy_step_done", 32'(step_done), 32'h0);
            end
            wb[i] = vmem_out;
            if (fires(a)) begin
                model_v[i] = 32'h0;
                chk("spike_valid", 32'(spike_valid), 32'h1);
                chk("spike_idx", 32'(spike_idx), 32'(i));
                chk("spike_vmem", vmem_out, 32'h0);
                step_spikes++;
                last_spike = int'(spike_idx);
                guard = 0;
                while (!spike_ready && guard < 300) begin
                    wait_neg(ab); waits++;
                    if (ab) return;
                    guard++;
                    chk("stall_spike_valid", 32'(spike_valid), 32'h1);
                    chk("stall_spike_idx", 32'(spike_idx), 32'(i));
                    chk("stall_cur_idx", 32'(cur_idx), 32'(i));
                end
                if (!spike_ready) begin
                    chk("spike_ack_timeout", 32'(spike_ready), 32'h1);
                    return;
                end
                wait_neg(ab); waits++;
                if (ab) return;
                chk("spike_dropped", 32'(spike_valid), 32'h0);
            end else begin
                model_v[i] = a;
                chk("quiet_spike_valid", 32'(spike_valid), 32'h0);
                chk("writeback", vmem_out, a);
            end
        end
        wait_neg(ab); waits++;
        if (ab) return;
        chk("step_done", 32'(step_done), 32'h1);
        chk("done_tick_ready", 32'(tick_ready), 32'h1);
        last_cycles = waits - 1;
        steps_done++;
    endtask

    // Compare process: idle/reset checks every cycle, full model during steps.
    initial begin : compare_proc
        zero_model();
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_tick_ready", 32'(tick_ready), 32'h1);
                chk("rst_spike_valid", 32'(spike_valid), 32'h0);
                chk("rst_spike_idx", 32'(spike_idx), 32'h0);
                chk("rst_vmem", vmem_out, 32'h0);
                chk("rst_step_done", 32'(step_done), 32'h0);
                chk("rst_cur_idx", 32'(cur_idx), 32'h0);
                zero_model();
            end else begin
                chk("idle_tick_ready", 32'(tick_ready), 32'h1);
                chk("idle_step_done", 32'(step_done), 32'h0);
                chk("idle_spike_valid", 32'(spike_valid), 32'h0);
                while (rst && tick_valid && !clr) check_step();
                if (rst && clr) zero_model();
            end
        end
    end

    task automatic start_tick();
        @(posedge clk); #1 tick_valid = 1'b1;
        @(posedge clk); #1 tick_valid = 1'b0;
    endtask

    task automatic wait_step(input int s);
        int c;
        c = 0;
        while (steps_done == s && c < 1000) begin
            @(posedge clk);
            c++;
        end
        if (steps_done == s) chk("step_timeout", 32'h0, 32'h1);
        @(posedge clk); #1;
    endtask

    task automatic do_step();
        int s;
        s = steps_done;
        start_tick();
        wait_step(s);
    endtask

    task automatic clr_pulse();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    task automatic wait_spike();
        int c;
        c = 0;
        while (!spike_valid && c < 200) begin
            @(posedge clk); #1;
            c++;
        end
        if (!spike_valid) chk("spike_wait_timeout", 32'h0, 32'h1);
    endtask

    task automatic fill_cur(input logic [31:0] val);
        for (int i = 0; i < N; i++) cur_mem[i] = val;
    endtask

    logic [31:0] lit3 [5];
    int          s0;
    int          p0;

    initial begin : main_proc
        lit3[0] = 32'h4000; lit3[1] = 32'h7800; lit3[2] = 32'hA900;
        lit3[3] = 32'hD3E0; lit3[4] = 32'hF964;
        rst = 1'b0; tick_valid = 1'b0; clr = 1'b0;
        fill_cur(32'h0);
        #1;
        chk("init_tick_ready", 32'(tick_ready), 32'h1);
        chk("init_spike_valid", 32'(spike_valid), 32'h0);
        chk("init_vmem", vmem_out, 32'h0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;

        // Uniform unit current from rest, two steps.
        fill_cur(32'h0001_0000);
        do_step();
        chk("t1_cycles", 32'(last_cycles), 32'd33);
        chk("t1_spikes", 32'(step_spikes), 32'h0);
        chk("t1_vmem", vmem_out, 32'h2000);
        for (int i = 0; i < N; i++) chk("t1_wb", wb[i], 32'h2000);
        do_step();
        chk("t1b_model", model_v[0], 32'h3C00);
        for (int i = 0; i < N; i++) chk("t1b_wb", wb[i], 32'h3C00);

        // Neuron 3 charges towards threshold, fires on step 6.
        clr_pulse();
        fill_cur(32'h0);
        cur_mem[3] = 32'h0002_0000;
        for (int s = 0; s < 5; s++) begin
            do_step();
            chk("t2_wb3", wb[3], lit3[s]);
            chk("t2_model3", model_v[3], lit3[s]);
            chk("t2_spikes", 32'(step_spikes), 32'h0);
        end
        do_step();
        chk("t2_spikes6", 32'(step_spikes), 32'h1);
        chk("t2_spike_idx", 32'(last_spike), 32'h3);
        chk("t2_wb3_6", wb[3], 32'h0);
        chk("t2_cycles6", 32'(last_cycles), 32'd34);

        // Same again with 10 cycles of backpressure on the spike.
        clr_pulse();
        for (int s = 0; s < 5; s++) do_step();
        chk("t3_wb3_pre", wb[3], 32'hF964);
        ready_force = 1'b0;
        s0 = steps_done;
        start_tick();
        wait_spike();
        chk("t3_spike_idx", 32'(spike_idx), 32'h3);
        repeat (10) @(posedge clk);
        #1 ready_force = 1'b1;
        wait_step(s0);
        chk("t3_cycles", 32'(last_cycles), 32'd44);
        chk("t3_spike", 32'(last_spike), 32'h3);

        // Negative current, no clamp.
        clr_pulse();
        fill_cur(32'hFFFF_0000);
        do_step();
        for (int i = 0; i < N; i++) chk("t4_wb", wb[i], 32'hFFFF_E000);
        chk("t4_spikes", 32'(step_spikes), 32'h0);

        // Mid-step tick ignored; clr beats a simultaneous tick.
        clr_pulse();
        fill_cur(32'h0001_0000);
        p0 = done_pulses;
        s0 = steps_done;
        start_tick();
        repeat (12) @(posedge clk);
        #1 tick_valid = 1'b1;
        @(posedge clk); #1 tick_valid = 1'b0;
        wait_step(s0);
        repeat (45) @(posedge clk);
        chk("t5_one_done", 32'(done_pulses - p0), 32'h1);
        @(posedge clk); #1 clr = 1'b1; tick_valid = 1'b1;
        @(posedge clk); #1 clr = 1'b0; tick_valid = 1'b0;
        repeat (3) @(posedge clk);
        chk("t5_clr_no_step", 32'(tick_ready), 32'h1);
        do_step();
        for (int i = 0; i < N; i++) chk("t5_wb", wb[i], 32'h2000);

        // Async reset while a spike is pending.
        clr_pulse();
        fill_cur(32'h0001_0000);
        cur_mem[5] = 32'h0008_0000;
        ready_force = 1'b0;
        start_tick();
        wait_spike();
        chk("t6_spike_idx", 32'(spike_idx), 32'h5);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("t6_async_valid", 32'(spike_valid), 32'h0);
        chk("t6_async_idx", 32'(spike_idx), 32'h0);
        chk("t6_async_vmem", vmem_out, 32'h0);
        chk("t6_async_ready", 32'(tick_ready), 32'h1);
        chk("t6_async_cur_idx", 32'(cur_idx), 32'h0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        ready_force = 1'b1;
        #1 chk("t6_release_ready", 32'(tick_ready), 32'h1);
        fill_cur(32'h0001_0000);
        do_step();
        for (int i = 0; i < N; i++) chk("t6_wb", wb[i], 32'h2000);

        // Randomized currents, random backpressure, occasional clears.
        ready_mode = 1'b1;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N; i++) begin
                cur_mem[i] = 32'($urandom_range(0, 32'h50000)) - 32'h0002_0000;
            end
            if ($urandom_range(0, 7) == 0) clr_pulse();
            do_step();
        end
        ready_mode = 1'b0;
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
